// File: rtl/add24_share_arbiter.sv
// -----------------------------------------------------------------------------
// add24_share_arbiter
//
// Purpose:
//   Shares a single 24-bit ripple-carry adder (sum modulo 2^24, carry out of
//   bit 23 dropped) among NREQ requesters of the FPU mantissa path. One
//   operand pair is accepted per cycle and its sum is held in a single-entry
//   output register with valid/ready handshaking. Each result carries the
//   index of the requester that produced it.
//
// Arbitration:
//   Default build      : round-robin. The search starts at the requester after
//                        the last winner, and the pointer only moves on a
//                        transfer.
//   ADD24_SHARE_FIXED_PRIO_EN defined : fixed priority, requester 0 highest.
//                        There is no pointer in this build, and high indices
//                        may starve.
//
// Ports:
//   clk        in   1        rising-edge clock
//   rst_n      in   1        synchronous active-low reset
//   req_valid  in   NREQ     requester i has an operand pair pending
//   req_ready  out  NREQ     one-hot (or zero) accept strobe
//   req_a      in   NREQ*W   operand A, requester i at [i*W +: W]
//   req_b      in   NREQ*W   operand B, same packing as req_a
//   rsp_valid  out  1        output register holds a valid sum
//   rsp_ready  in   1        consumer takes the result this cycle
//   rsp_sum    out  W        registered (a+b) mod 2^24
//   rsp_id     out  IDW      requester index that produced rsp_sum
//   busy       out  1        mirror of rsp_valid, for stall visibility
//
// Parameter constraints: W must be 24 (the adder is fixed at 24 bits), and
// IDW must equal clog2(NREQ), with NREQ in 2..8.
// -----------------------------------------------------------------------------

// One-bit half adder: the least significant bit of the ripple chain.
module add24_half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule

// One-bit full adder: the middle bits of the ripple chain.
module add24_full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);
  assign o_s  = i_a ^ i_b ^ i_ci;
  assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));
endmodule

// 24-bit ripple adder, modulo 2^24.
module add24_ripple (
  input  logic [23:0] i_a,
  input  logic [23:0] i_b,
  output logic [23:0] o_s
);
  logic [22:0] w_carry;

  add24_half_adder u_ha0 (
    .i_a (i_a[0]),
    .i_b (i_b[0]),
    .o_s (o_s[0]),
    .o_c (w_carry[0])
  );

  genvar gi;
  for (gi = 1; gi < 23; gi++) begin : g_fa
    add24_full_adder u_fa (
      .i_a  (i_a[gi]),
      .i_b  (i_b[gi]),
      .i_ci (w_carry[gi-1]),
      .o_s  (o_s[gi]),
      .o_co (w_carry[gi])
    );
  end

  // The carry out of bit 23 would be discarded anyway, so the top bit
  // only needs its sum term.
  assign o_s[23] = i_a[23] ^ i_b[23] ^ w_carry[22];
endmodule

module add24_share_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 24,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W-1:0]      rsp_sum,
  output logic [IDW-1:0]    rsp_id,
  output logic              busy
);

  // The output register's occupancy is the whole state: EMPTY/FULL is
  // exactly rsp_valid.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [W-1:0]    r_sum;
  logic [IDW-1:0]  r_id;
`ifndef ADD24_SHARE_FIXED_PRIO_EN
  logic [IDW-1:0]  r_rr_ptr;
`endif

  logic [IDW-1:0]  w_ptr;
  logic            w_acc_en;
  logic            w_any;
  logic            w_xfer;
  logic [NREQ-1:0] w_grant_oh;
  logic [NREQ-1:0] w_req_ready;
  logic [IDW-1:0]  w_grant_id;
  logic [W-1:0]    w_op_a;
  logic [W-1:0]    w_op_b;
  logic [W-1:0]    w_sum;

  // A new operand pair may enter when the register is empty, or when the
  // register drains in the same edge.
  assign w_acc_en = (r_state == ST_EMPTY) | rsp_ready;

`ifdef ADD24_SHARE_FIXED_PRIO_EN
  assign w_ptr = {IDW{1'b0}};
`else
  assign w_ptr = r_rr_ptr;
`endif

  // Grant search: first valid requester at or after w_ptr, wrapping modulo NREQ.
  always_comb begin
    logic [IDW-1:0] v_idx;
    v_idx      = {IDW{1'b0}};
    w_grant_oh = {NREQ{1'b0}};
    w_grant_id = {IDW{1'b0}};
    w_any      = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      v_idx = IDW'((int'(w_ptr) + k) % NREQ);
      if (!w_any && req_valid[v_idx]) begin
        w_any             = 1'b1;
        w_grant_id        = v_idx;
        w_grant_oh[v_idx] = 1'b1;
      end else begin
        // An earlier candidate in the search order keeps the grant.
      end
    end
  end

  // Accept strobe: held at zero during reset and while the output is stalled.
  always_comb begin
    if (rst_n && w_acc_en) begin
      w_req_ready = w_grant_oh;
    end else begin
      w_req_ready = {NREQ{1'b0}};
    end
  end

  assign req_ready = w_req_ready;
  assign w_xfer    = |(req_valid & w_req_ready);

  // One-hot AND-OR operand mux in front of the shared adder.
  always_comb begin
    w_op_a = {W{1'b0}};
    w_op_b = {W{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      w_op_a = w_op_a | (req_a[i*W +: W] & {W{w_grant_oh[i]}});
      w_op_b = w_op_b | (req_b[i*W +: W] & {W{w_grant_oh[i]}});
    end
  end

  add24_ripple u_add (
    .i_a (w_op_a),
    .i_b (w_op_b),
    .o_s (w_sum)
  );

  // State register of the output stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: a transfer always fills the register. Draining without a
  // refill empties it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_xfer) begin
          w_state_nxt = ST_FULL;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_xfer) begin
          w_state_nxt = ST_FULL;
        end else if (rsp_ready) begin
          w_state_nxt = ST_EMPTY;
        end else begin
          w_state_nxt = ST_FULL;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  // Result and tag capture. Both hold their values across a drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum <= {W{1'b0}};
      r_id  <= {IDW{1'b0}};
    end else if (w_xfer) begin
      r_sum <= w_sum;
      r_id  <= w_grant_id;
    end else begin
      r_sum <= r_sum;
      r_id  <= r_id;
    end
  end

`ifndef ADD24_SHARE_FIXED_PRIO_EN
  // Round-robin pointer: moves past the winner, and only on a transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr <= {IDW{1'b0}};
    end else if (w_xfer) begin
      r_rr_ptr <= IDW'((int'(w_grant_id) + 1) % NREQ);
    end else begin
      r_rr_ptr <= r_rr_ptr;
    end
  end
`endif

  assign rsp_valid = (r_state == ST_FULL);
  assign rsp_sum   = r_sum;
  assign rsp_id    = r_id;
  assign busy      = (r_state == ST_FULL);

endmodule

// File: tb/tb_add24_share_arbiter.sv
// Testbench for add24_share_arbiter. The directed scenarios are followed by
// a randomized phase. Expectations come from a queue-free reference model:
// per-requester pending slots, a result slot, and a pointer. The model
// works on plain integers.
module tb_add24_share_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 24;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W-1:0]      rsp_sum;
  logic [IDW-1:0]    rsp_id;
  logic              busy;

  add24_share_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Requester-side pending operands
  bit          pv [NREQ];
  logic [23:0] pa [NREQ];
  logic [23:0] pb [NREQ];

  // Reference model state
  bit          m_valid = 1'b0;
  logic [23:0] m_sum   = 24'h0;
  int          m_id    = 0;
  int          m_ptr   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] ref_add(input logic [23:0] a, input logic [23:0] b);
    longint unsigned s;
    s = (longint'(a) + longint'(b)) % 64'd16777216;
    return s[23:0];
  endfunction

  function automatic int ref_grant();
    int i;
    if (!rst_n) return -1;
    if (m_valid && !rsp_ready) return -1;
    for (int k = 0; k < NREQ; k++) begin
      i = (m_ptr + k) % NREQ;
      if (pv[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [23:0] rnd24();
    int unsigned r;
    r = $urandom % 8;
    case (r)
      0:       return 24'hFFFFFF;
      1:       return 24'h000000;
      2:       return 24'h800000;
      default: return 24'($urandom);
    endcase
  endfunction

  task automatic present(input int i, input logic [23:0] a, input logic [23:0] b);
    pv[i] = 1'b1;
    pa[i] = a;
    pb[i] = b;
  endtask

  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]       = pv[i];
      req_a[i*W +: W]    = pa[i];
      req_b[i*W +: W]    = pb[i];
    end
  endtask

  // One clock cycle. Inputs are applied, then req_ready is checked at the
  // negative edge. After the rising edge the model is advanced and the
  // registered outputs are checked.
  task automatic cycle(output int g, output logic [NREQ-1:0] rdy_obs);
    logic [NREQ-1:0] exp_rdy;
    apply();
    #4;
    g = ref_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    rdy_obs = req_ready;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 1'b0; m_sum = 24'h0; m_id = 0; m_ptr = 0;
    end else if (g >= 0) begin
      m_sum   = ref_add(pa[g], pb[g]);
      m_id    = g;
      m_valid = 1'b1;
`ifndef ADD24_SHARE_FIXED_PRIO_EN
      m_ptr   = (g + 1) % NREQ;
`endif
      pv[g]   = 1'b0;
    end else if (m_valid && rsp_ready) begin
      m_valid = 1'b0;
    end
    #1;
    check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    check("busy",      32'(busy),      32'(m_valid));
    check("rsp_sum",   32'(rsp_sum),   32'(m_sum));
    check("rsp_id",    32'(rsp_id),    32'(m_id));
  endtask

  task automatic clear_all();
    for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
  endtask

  int              g;
  logic [NREQ-1:0] rdy;
  int              seq [6];
  logic [23:0]     held_sum;
  int              held_id;

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      pv[i] = 1'b0; pa[i] = 24'h0; pb[i] = 24'h0;
    end
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    apply();
    @(posedge clk);
    #1;

    // Reset state
    cycle(g, rdy);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_sum",   32'(rsp_sum),   32'd0);
    rst_n = 1'b1;

    // 1. Basic add
    present(1, 24'h000001, 24'h000002);
    cycle(g, rdy);
    check("t1_ready", 32'(rdy), 32'h2);
    check("t1_valid", 32'(rsp_valid), 32'd1);
    check("t1_id",    32'(rsp_id),    32'd1);
    check("t1_sum",   32'(rsp_sum),   32'h000003);
    cycle(g, rdy);
    check("t1_drain", 32'(rsp_valid), 32'd0);

    // 2. Wrap-around
    present(0, 24'hFFFFFF, 24'h000001);
    cycle(g, rdy);
    check("t2_wrap1", 32'(rsp_sum), 32'h000000);
    present(0, 24'h800000, 24'h800000);
    cycle(g, rdy);
    check("t2_wrap2", 32'(rsp_sum), 32'h000000);
    present(0, 24'h7FFFFF, 24'h000001);
    cycle(g, rdy);
    check("t2_carry", 32'(rsp_sum), 32'h800000);
    cycle(g, rdy);

    // 3. Arbitration order with all requesters continuously pending
    rst_n = 1'b0;
    cycle(g, rdy);
    rst_n = 1'b1;
`ifdef ADD24_SHARE_FIXED_PRIO_EN
    seq = '{0, 0, 0, 0, 0, 0};
`else
    seq = '{0, 1, 2, 3, 0, 1};
`endif
    for (int i = 0; i < NREQ; i++) present(i, rnd24(), rnd24());
    for (int j = 0; j < 6; j++) begin
      cycle(g, rdy);
      check("t3_id_seq", 32'(rsp_id), 32'(seq[j]));
      if (g >= 0) present(g, rnd24(), rnd24());
    end

    // 4. Backpressure: result held, nothing accepted
    rsp_ready = 1'b0;
    held_sum  = m_sum;
    held_id   = m_id;
    for (int j = 0; j < 3; j++) begin
      cycle(g, rdy);
      check("t4_ready0", 32'(rdy),       32'd0);
      check("t4_hold_v", 32'(rsp_valid), 32'd1);
      check("t4_hold_s", 32'(rsp_sum),   32'(held_sum));
      check("t4_hold_i", 32'(rsp_id),    32'(held_id));
    end
    rsp_ready = 1'b1;
    cycle(g, rdy);
    check("t4_refill_v", 32'(rsp_valid), 32'd1);
`ifdef ADD24_SHARE_FIXED_PRIO_EN
    check("t4_next_id", 32'(rsp_id), 32'd0);
`else
    check("t4_next_id", 32'(rsp_id), 32'd2);
`endif
    if (g >= 0) present(g, rnd24(), rnd24());

    // 5. Reset mid-operation with a result held (pointer at 2 in round-robin)
    clear_all();
    present(1, rnd24(), rnd24());
    cycle(g, rdy);
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    cycle(g, rdy);
    check("t5_rdy_rst", 32'(rdy),       32'd0);
    check("t5_valid",   32'(rsp_valid), 32'd0);
    check("t5_sum",     32'(rsp_sum),   32'd0);
    check("t5_id",      32'(rsp_id),    32'd0);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) present(i, rnd24(), rnd24());
    cycle(g, rdy);
    check("t5_first", 32'(rsp_id), 32'd0);
    clear_all();

    // 6. An idle stretch must not move the pointer
    present(2, rnd24(), rnd24());
    cycle(g, rdy);
    check("t6_g2", 32'(rsp_id), 32'd2);
    for (int j = 0; j < 5; j++) cycle(g, rdy);
    present(0, rnd24(), rnd24());
    present(3, rnd24(), rnd24());
    cycle(g, rdy);
`ifdef ADD24_SHARE_FIXED_PRIO_EN
    check("t6_after_idle", 32'(rsp_id), 32'd0);
`else
    check("t6_after_idle", 32'(rsp_id), 32'd3);
`endif
    clear_all();
    cycle(g, rdy);

    // Randomized traffic: requesters hold pending pairs until accepted
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pv[i] && ($urandom % 2 == 0)) present(i, rnd24(), rnd24());
      end
      rsp_ready = ($urandom % 4 != 0);
      rst_n     = ($urandom % 64 != 0);
      cycle(g, rdy);
    end
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/add24_share_arbiter.md
Name: add24_share_arbiter

Overview:
- Shares one combinational 24-bit ripple adder (half_adder/full_adder chain, sum modulo 2^24, no carry-out) among NREQ requesters in the FPU mantissa path (e.g. FP add alignment, FP mul rounding increment, normalisation).
- Arbitrates among requesters and accepts one operand pair per cycle.
- Registers the sum in a single-entry output stage with valid/ready backpressure.
- Tags each result with the ID of the requester that produced it.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 24, operand/sum width; the adder instance is fixed at 24, so W must equal 24.
- IDW, 2, requester ID width; must equal clog2(NREQ).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; synchronous, active-low.
- req_valid  input  NREQ  bit i: requester i has an operand pair pending.
- req_ready  output  NREQ  bit i: requester i accepted this cycle; one-hot or zero.
- req_a  input  NREQ*W  operand A; requester i occupies bits [i*W +: W].
- req_b  input  NREQ*W  operand B; same packing as req_a.
- rsp_valid  output  1  result register holds a valid sum.
- rsp_ready  input  1  consumer takes the result this cycle.
- rsp_sum  output  W  registered (a+b) mod 2^24.
- rsp_id  output  IDW  index of the requester that produced rsp_sum.
- busy  output  1  equals rsp_valid; used for pipeline-stall visibility.

Behaviour:
- Reset (rst_n low at a rising edge):
  - rsp_valid=0, rsp_sum=0, rsp_id=0, rr_ptr=0.
  - req_ready forced to all-zero while rst_n is low.
  - An in-flight result is discarded; a requester whose transfer was not yet accepted must re-present it.
- State machine, 2 states, encoded by rsp_valid:
  - EMPTY: no result held.
  - FULL: result held.
- Accept enable: acc_en = !rsp_valid | rsp_ready. Back-to-back throughput is 1 result/cycle.
- Grant (combinational, when acc_en=1):
  - Pick the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ..., wrapping modulo NREQ.
  - req_ready[g]=1 for the winner g; all other bits 0.
  - acc_en=0 or no valid request: req_ready all-zero.
- Transfer: occurs when req_valid[g] & req_ready[g] at a rising edge. At that edge:
  - rsp_sum <= adder(req_a[g], req_b[g]).
  - rsp_id <= g.
  - rsp_valid <= 1.
  - rr_ptr <= (g+1) mod NREQ.
- Latency: exactly 1 cycle from accepting edge to rsp_valid=1.
- Drain without new transfer: rsp_valid & rsp_ready, no transfer → rsp_valid <= 0. rsp_sum and rsp_id hold their old values.
- Simultaneous drain and accept: the new result replaces the old in the same edge; rsp_valid stays 1.
- FULL with rsp_ready=0: rsp_sum/rsp_id/rsp_valid hold stable, req_ready=0, rr_ptr unchanged.
- rr_ptr changes only on a transfer; an idle cycle never advances it.
- Requester rules:
  - Once req_valid[i] rises, requester i holds req_valid[i], req_a and req_b stable until accepted.
  - The arbiter does not check this.
- Arithmetic: unsigned modulo 2^24; carry out of bit 23 is dropped (0xFFFFFF+0x000001=0x000000).
- The adder is instantiated once. Operand muxes are one-hot, driven by the grant.

Optional Feature:
- Macro: ADD24_SHARE_FIXED_PRIO_EN.
- Defined:
  - Fixed priority, lowest index wins (requester 0 highest).
  - rr_ptr is removed and treated as constant 0.
  - Starvation of high indices is permitted.
- Undefined (default): round-robin as described in Behaviour.

Test Plan:
1. Basic add:
   - Stimulus: only req_valid[1]=1, a=0x000001, b=0x000002, rsp_ready=1.
   - Response: req_ready=4'b0010 in that cycle; next cycle rsp_valid=1, rsp_id=1, rsp_sum=0x000003; following cycle rsp_valid=0.
2. Wrap-around:
   - Stimulus: requester 0, a=0xFFFFFF, b=0x000001.
   - Response: rsp_sum=0x000000.
   - Stimulus: a=0x800000, b=0x800000.
   - Response: rsp_sum=0x000000.
   - Stimulus: a=0x7FFFFF, b=0x000001.
   - Response: rsp_sum=0x800000.
3. Arbitration:
   - Stimulus: all four req_valid held high, each requester re-presenting after acceptance, rsp_ready=1.
   - Response (round-robin): rsp_id sequence 0,1,2,3,0,1 on consecutive cycles.
   - Response (ADD24_SHARE_FIXED_PRIO_EN): rsp_id=0 every cycle.
4. Backpressure:
   - Stimulus: result held, rsp_ready=0 for 3 cycles with req_valid=4'b1111.
   - Response: req_ready=0; rsp_sum, rsp_id, rsp_valid unchanged; rr_ptr unchanged.
   - Stimulus: raise rsp_ready.
   - Response: same edge drains the old result and accepts the next requester in round-robin order; rsp_valid stays 1.
5. Reset mid-operation:
   - Stimulus: rst_n=0 for one edge while rsp_valid=1 and rr_ptr=2.
   - Response: rsp_valid=0, rsp_sum=0, rsp_id=0, req_ready=0 during reset.
   - Stimulus: after release, all requesting.
   - Response: first grant goes to requester 0.
6. Idle pointer hold:
   - Stimulus: grant to requester 2, then 5 idle cycles, then req_valid=4'b1001.
   - Response: grant goes to 3.
